serial_word_comparator: RTL and testbench

- Parametrised successor to the single-bit x/y -> z experiment block.
- Compares two WIDTH-bit operands presented serially, one bit pair (x, y) per accepted clock, and reports x>y on z plus eq/lt flags at word end.
- Sits between serial bit sources (shift registers or switch debouncers) and the result display/LED logic in the lab designs.
- Bit order and signed/unsigned interpretation are selectable.

---
 rtl/lab_pkg.sv | 17 +
 rtl/cmp_bit_cell.sv | 33 +++
 rtl/serial_word_comparator.sv | 107 ++++++++++
 tb/tb_serial_word_comparator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared encodings for the serial word comparator: FSM states and the
// three-way comparison decision.
package lab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_e;

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit comparison step: folds a single (x, y) bit pair into the running
// X-vs-Y decision, honouring stream order and two's-complement sign bit.
module cmp_bit_cell
  import lab_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic [1:0] dec_i,
  input  logic       x,
  input  logic       y,
  input  logic       is_sign_bit,
  output logic [1:0] dec_o
);

  cmp_e sense;

  always_comb begin
    sense = (x & ~y) ? CMP_GT : CMP_LT;
    // A set sign bit makes the operand smaller, so the sense flips.
    if (SIGNED != 0 && is_sign_bit)
      sense = (sense == CMP_GT) ? CMP_LT : CMP_GT;

    dec_o = dec_i;
    // MSB-first: first difference is final. LSB-first: later bits are more
    // significant, so every difference overwrites.
    if (x != y) begin
      if (MSB_FIRST == 0 || dec_i == CMP_EQ)
        dec_o = sense;
    end
  end

endmodule

// File: rtl/serial_word_comparator.sv
// Serial WIDTH-bit comparator: collects one (x, y) bit pair per valid cycle
// and publishes registered gt/eq/lt flags with a done pulse at word end.
module serial_word_comparator
  import lab_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       bit_valid,
  input  logic                       x,
  input  logic                       y,
  output logic                       busy,
  output logic                       done,
  output logic                       z,
  output logic                       eq,
  output logic                       lt,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmp_e          dec_q, dec_d;
  cmp_e          res_q, res_d;
  logic [1:0]    dec_nxt;
  logic          sign_bit;

  // The sign bit is the first bit of the stream MSB-first, the last one LSB-first.
  assign sign_bit = (MSB_FIRST != 0) ? (cnt_q == '0) : (cnt_q == LAST);

  cmp_bit_cell #(
    .MSB_FIRST (MSB_FIRST),
    .SIGNED    (SIGNED)
  ) u_cell (
    .dec_i       (dec_q),
    .x           (x),
    .y           (y),
    .is_sign_bit (sign_bit),
    .dec_o       (dec_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    res_d   = res_q;
    if (start) begin
      // Start from any state (re)opens a word; a bit in this cycle is dropped.
      state_d = ST_SHIFT;
      cnt_d   = '0;
      dec_d   = CMP_EQ;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SHIFT: begin
          if (bit_valid) begin
            dec_d = cmp_e'(dec_nxt);
            if (cnt_q == LAST) begin
              cnt_d   = FULL;
              res_d   = cmp_e'(dec_nxt);
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= CMP_EQ;
      res_q   <= CMP_EQ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      res_q   <= res_d;
    end
  end

  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign z       = (res_q == CMP_GT);
  assign eq      = (res_q == CMP_EQ);
  assign lt      = (res_q == CMP_LT);
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Drives one shared bit stream into four comparator variants (MSB/LSB first,
// unsigned/signed) and checks each against an integer-compare reference.
module tb_serial_word_comparator;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, x, y;
  logic [3:0]      busy_w, done_w, z_w, eq_w, lt_w;
  logic [3:0][3:0] cnt_w;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] ez, ee, el;

  always #5 clk = ~clk;

  // g[1]=0 -> MSB first, g[0]=1 -> signed
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_word_comparator #(
      .WIDTH     (8),
      .MSB_FIRST ((g < 2) ? 1 : 0),
      .SIGNED    (g % 2)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bit_valid (bit_valid),
      .x         (x),
      .y         (y),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .z         (z_w[g]),
      .eq        (eq_w[g]),
      .lt        (lt_w[g]),
      .bit_cnt   (cnt_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stream bit k is sx[7-k]. Rebuild the operand as each variant sees it and
  // compare as plain integers. Returns {gt, eq, lt}.
  function automatic logic [2:0] model(input logic [7:0] sx, input logic [7:0] sy,
                                       input bit msb, input bit sgn);
    logic [7:0] a, b;
    int xv, yv;
    for (int i = 0; i < 8; i++) begin
      a[i] = msb ? sx[i] : sx[7-i];
      b[i] = msb ? sy[i] : sy[7-i];
    end
    xv = int'(a);
    yv = int'(b);
    if (sgn && a[7]) xv -= 256;
    if (sgn && b[7]) yv -= 256;
    return {xv > yv, xv == yv, xv < yv};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_busy"}, busy_w, 4'h0);
    check({tag, "_done"}, done_w, 4'h0);
    check({tag, "_res"}, {z_w, eq_w, lt_w}, {4'h0, 4'hF, 4'h0});
    check({tag, "_cnt"}, cnt_w, 16'h0);
  endtask

  task automatic chk_shift(input int k);
    check("shift_busy", busy_w, 4'hF);
    check("shift_done", done_w, 4'h0);
    check("shift_cnt", cnt_w[0], k);
    check("shift_held", {z_w, eq_w, lt_w}, {ez, ee, el});
  endtask

  // stall: 0 none, 1 alternate, 2 random. restart_at/reset_at: bit index or -1.
  task automatic run_word(input logic [7:0] sx, input logic [7:0] sy, input int stall,
                          input int restart_at, input int reset_at);
    int k, n;
    bit tog;
    logic [2:0] r;
    @(negedge clk);
    start = 1'b1; bit_valid = 1'($urandom_range(0, 1));
    x = 1'($urandom); y = 1'($urandom);
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0;
    k = 0; n = 0; tog = 1'b0;
    while (k < 8 && n < 200) begin
      n++;
      chk_shift(k);
      if (k == reset_at) begin
        reset_at = -1;
        #1 rst_n = 1'b0;
        #1 chk_idle_outputs("async_rst");
        #1 rst_n = 1'b1;
        ez = 4'h0; ee = 4'hF; el = 4'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        continue;
      end
      if (k == restart_at) begin
        restart_at = -1;
        start = 1'b1; bit_valid = 1'b1;
        x = 1'($urandom); y = 1'($urandom);
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
        k = 0;
        continue;
      end
      tog = ~tog;
      if ((stall == 1 && tog) || (stall == 2 && $urandom_range(0, 2) == 0)) begin
        bit_valid = 1'b0; x = 1'($urandom); y = 1'($urandom);
        @(negedge clk);
        continue;
      end
      bit_valid = 1'b1; x = sx[7-k]; y = sy[7-k];
      @(negedge clk);
      bit_valid = 1'b0;
      k++;
    end
    if (k != 8) check("word_timeout", k, 8);
    for (int g = 0; g < 4; g++) begin
      r = model(sx, sy, g < 2, g[0]);
      ez[g] = r[2]; ee[g] = r[1]; el[g] = r[0];
    end
    check("done_pulse", done_w, 4'hF);
    check("done_busy", busy_w, 4'h0);
    check("done_cnt", cnt_w[0], 8);
    check("result", {z_w, eq_w, lt_w}, {ez, ee, el});
    check("onehot", {4'(z_w + eq_w + lt_w)} == 4'h0 ? 0 : 1, 1);
    @(negedge clk);
    check("post_done", done_w, 4'h0);
    check("post_cnt", cnt_w[0], 0);
    check("post_held", {z_w, eq_w, lt_w}, {ez, ee, el});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; x = 1'b0; y = 1'b0;
    ez = 4'h0; ee = 4'hF; el = 4'h0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    run_word(8'hA5, 8'hA4, 0, -1, -1);
    check("a5_a4_gt", z_w[0], 1'b1);
    run_word(8'h3C, 8'h3C, 1, -1, -1);
    check("eq_stall", eq_w, 4'hF);
    run_word(8'h80, 8'h7F, 0, -1, -1);
    check("signed_lt", lt_w[1], 1'b1);
    check("unsigned_gt", z_w[0], 1'b1);
    run_word(8'h7F, 8'h80, 2, -1, -1);
    check("signed_swap_gt", z_w[1], 1'b1);
    // LSB-first X=0x01, Y=0x80: first stream bits are X[0]=1, Y[0]=0.
    run_word(8'h80, 8'h01, 0, -1, -1);
    check("lsb_lt", lt_w[2], 1'b1);
    run_word(8'h10, 8'h20, 0, 4, -1);
    check("restart_lt", lt_w[0], 1'b1);
    run_word(8'($urandom), 8'($urandom), 2, -1, 3);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 4 == 0) ? a ^ (8'h1 << $urandom_range(0, 7)) : 8'($urandom);
      run_word(a, b, i % 3, (i % 5 == 0) ? int'($urandom_range(0, 7)) : -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
